// File: rtl/half_duplex_spi_pkg.sv
// Shared types and constants for the 3-wire SPI register-access responder.
package half_duplex_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INSTR = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } slave_state_t;

    localparam logic SPI_RW_READ  = 1'b1;
    localparam logic SPI_RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the synchronizer chain and keep the last settled level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= STAGES'({r_sync, i_d});
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/half_duplex_spi_slave.sv
// 3-wire SPI responder: oversamples SCLK/CS_N/SDIO, decodes R/W + address,
// then issues a register write or shifts register read data back on SDIO.
module half_duplex_spi_slave
    import half_duplex_spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  fabric_clk,
    input  logic                  reset,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    inout  wire                   spi_sdio,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

    slave_state_t          r_state;
    logic                  r_cpol;
    logic                  r_cpha;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-2:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_shift_out;
    logic                  r_sdio_oe;
    logic                  r_sdio_out;
    logic                  r_wr_pend;
    logic                  r_rd_load;

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_sdio, w_sdio_rise, w_sdio_fall;
    logic w_lead, w_trail, w_sample, w_drive;
    logic w_unused;
    logic [ADDR_WIDTH:0]   w_instr_next;
    logic [DATA_WIDTH-1:0] w_wdata_next;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(fabric_clk), .rst(reset), .i_d(spi_sclk),
        .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(fabric_clk), .rst(reset), .i_d(spi_cs_n),
        .o_q(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdio (
        .clk(fabric_clk), .rst(reset), .i_d(spi_sdio),
        .o_q(w_sdio), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall)
    );

    assign w_unused = w_sclk ^ w_sdio_rise ^ w_sdio_fall;

    // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
    assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_drive  = r_cpha ? w_lead : w_trail;

    assign w_instr_next = {r_instr, w_sdio};
    assign w_wdata_next = {r_wdata, w_sdio};

    assign spi_sdio = r_sdio_oe ? r_sdio_out : 1'bz;

    // Frame sequencer: instruction decode, write capture, read shift-out, abort.
    always_ff @(posedge fabric_clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_instr     <= {ADDR_WIDTH{1'b0}};
            r_wdata     <= {(DATA_WIDTH-1){1'b0}};
            r_shift_out <= {DATA_WIDTH{1'b0}};
            r_sdio_oe   <= 1'b0;
            r_sdio_out  <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_rd_load   <= 1'b0;
            reg_addr    <= {ADDR_WIDTH{1'b0}};
            reg_wr_data <= {DATA_WIDTH{1'b0}};
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            reg_wr_en   <= r_wr_pend;
            r_wr_pend   <= 1'b0;
            reg_rd_en   <= 1'b0;
            frame_error <= 1'b0;
            // Read data is taken one cycle after the strobe is visible.
            r_rd_load   <= reg_rd_en;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_cpol    <= spi_cpol;
                        r_cpha    <= spi_cpha;
                        r_bit_cnt <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                        r_state   <= INSTR;
                    end
                end
                INSTR: begin
                    if (w_cs_rise) begin
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_sample) begin
                        r_instr   <= w_instr_next[ADDR_WIDTH-1:0];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == INSTR_LAST) begin
                            reg_addr <= w_instr_next[ADDR_WIDTH-1:0];
                            if (w_instr_next[ADDR_WIDTH] == SPI_RW_WRITE) begin
                                r_state <= WDATA;
                            end else begin
                                reg_rd_en <= 1'b1;
                                r_state   <= RDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (w_cs_rise) begin
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_sample) begin
                        r_wdata   <= w_wdata_next[DATA_WIDTH-2:0];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == FRAME_LAST) begin
                            reg_wr_data <= w_wdata_next;
                            r_wr_pend   <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                RDATA: begin
                    if (w_cs_rise) begin
                        frame_error <= 1'b1;
                        r_sdio_oe   <= 1'b0;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_rd_load) begin
                        r_shift_out <= reg_rd_data;
                    end else if (w_sample) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == FRAME_LAST) begin
                            r_sdio_oe <= 1'b0;
                            r_state   <= DONE;
                        end
                    end else if (w_drive) begin
                        r_sdio_oe   <= 1'b1;
                        r_sdio_out  <= r_shift_out[DATA_WIDTH-1];
                        r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    if (w_cs_n) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_sdio_oe <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// Directed bench: a behavioural SPI master and register-file model drive the
// responder through writes, reads, aborts, extra clocks and a mid-frame reset.
module tb_half_duplex_spi_slave;
    import half_duplex_spi_pkg::*;

    localparam int HALF = 80;

    logic       fabric_clk = 1'b0;
    logic       reset      = 1'b1;
    logic       spi_cpol   = 1'b0;
    logic       spi_cpha   = 1'b0;
    logic       spi_sclk   = 1'b0;
    logic       spi_cs_n   = 1'b1;
    wire        spi_sdio;
    logic       m_oe       = 1'b0;
    logic       m_out      = 1'b0;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic       busy;
    logic       frame_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:127];
    int         wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, oe_cycles = 0;
    logic [6:0] last_wr_addr = 7'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic       rd_force = 1'b0;
    logic [7:0] rd_force_val = 8'h00;
    logic       oe_pre = 1'b0, oe_post = 1'b0, busy_mid = 1'b0;
    logic [7:0] rx_val;
    int         w0, r0, f0, o0;

    assign spi_sdio = m_oe ? m_out : 1'bz;

    always #5 fabric_clk = ~fabric_clk;

    half_duplex_spi_slave dut (
        .fabric_clk (fabric_clk),
        .reset      (reset),
        .spi_cpol   (spi_cpol),
        .spi_cpha   (spi_cpha),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_sdio   (spi_sdio),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .busy       (busy),
        .frame_error(frame_error)
    );

    // Register-file model with one-cycle registered read, plus event counters.
    always @(posedge fabric_clk) begin
        if (reg_wr_en) begin
            mem[reg_addr] <= reg_wr_data;
            last_wr_addr  <= reg_addr;
            last_wr_data  <= reg_wr_data;
            wr_cnt        <= wr_cnt + 1;
        end
        if (reg_rd_en) begin
            reg_rd_data <= rd_force ? rd_force_val : mem[reg_addr];
            rd_cnt      <= rd_cnt + 1;
        end
        if (frame_error) ferr_cnt <= ferr_cnt + 1;
        if (dut.r_sdio_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic spi_xfer(input logic cpol, input logic cpha, input int ncyc,
                            input logic [15:0] tx, input bit rd, input bit keep_cs,
                            output logic [7:0] rx);
        @(negedge fabric_clk);
        spi_cpol = cpol; spi_cpha = cpha; spi_sclk = cpol; m_oe = 1'b0; rx = 8'h00;
        #(HALF);
        spi_cs_n = 1'b0;
        if (!cpha) begin m_oe = 1'b1; m_out = tx[15]; end
        #(HALF);
        for (int i = 0; i < ncyc; i++) begin
            if (i == 2) busy_mid = busy;
            if (cpha && i == 8) oe_pre = dut.r_sdio_oe;
            spi_sclk = ~cpol;
            if (cpha) begin
                if (i < 16 && !(rd && i >= 8)) begin m_oe = 1'b1; m_out = tx[15-i]; end
                else m_oe = 1'b0;
            end else if (rd && i >= 8 && i < 16) rx = {rx[6:0], spi_sdio};
            #(HALF);
            if (!cpha && i == 7) oe_pre = dut.r_sdio_oe;
            spi_sclk = cpol;
            if (cpha) begin
                if (rd && i >= 8 && i < 16) rx = {rx[6:0], spi_sdio};
            end else begin
                if ((i + 1) < 16 && !(rd && (i + 1) >= 8)) begin m_oe = 1'b1; m_out = tx[14-i]; end
                else m_oe = 1'b0;
            end
            #(HALF);
        end
        oe_post = dut.r_sdio_oe;
        m_oe = 1'b0;
        if (!keep_cs) begin
            spi_cs_n = 1'b1;
            #(4*HALF);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge fabric_clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0 || frame_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b%b%b want 000", reg_wr_en, reg_rd_en, frame_error); end
        n_tests++; if (reg_addr !== 7'h00 || reg_wr_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_regs: got %h/%h want 00/00", reg_addr, reg_wr_data); end
        n_tests++; if (dut.r_sdio_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", dut.r_sdio_oe); end
        reset = 1'b0;
        repeat (4) @(negedge fabric_clk);
    endtask

    task automatic test_write_mode0();
        w0 = wr_cnt; o0 = oe_cycles;
        spi_xfer(1'b0, 1'b0, 16, {SPI_RW_WRITE, 7'h15, 8'hA5}, 1'b0, 1'b0, rx_val);
        n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr0_count: got %0d want 1", wr_cnt - w0); end
        n_tests++; if (last_wr_addr !== 7'h15) begin n_fail++; $display("FAIL wr0_addr: got %h want 15", last_wr_addr); end
        n_tests++; if (last_wr_data !== 8'hA5) begin n_fail++; $display("FAIL wr0_data: got %h want a5", last_wr_data); end
        n_tests++; if (oe_cycles - o0 !== 0) begin n_fail++; $display("FAIL wr0_sdio_driven: got %0d cycles want 0", oe_cycles - o0); end
        n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL wr0_busy_mid: got %b want 1", busy_mid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr0_busy_end: got %b want 0", busy); end
        n_tests++; if (reg_addr !== 7'h15) begin n_fail++; $display("FAIL wr0_addr_hold: got %h want 15", reg_addr); end
    endtask

    task automatic test_read_mode3();
        rd_force = 1'b1; rd_force_val = 8'h3C;
        r0 = rd_cnt; w0 = wr_cnt;
        spi_xfer(1'b1, 1'b1, 16, {SPI_RW_READ, 7'h2A, 8'h00}, 1'b1, 1'b0, rx_val);
        rd_force = 1'b0;
        n_tests++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL rd3_count: got %0d want 1", rd_cnt - r0); end
        n_tests++; if (rx_val !== 8'h3C) begin n_fail++; $display("FAIL rd3_data: got %h want 3c", rx_val); end
        n_tests++; if (oe_pre !== 1'b0) begin n_fail++; $display("FAIL rd3_oe_before_drive: got %b want 0", oe_pre); end
        n_tests++; if (oe_post !== 1'b0) begin n_fail++; $display("FAIL rd3_oe_after_last: got %b want 0", oe_post); end
        n_tests++; if (reg_addr !== 7'h2A) begin n_fail++; $display("FAIL rd3_addr: got %h want 2a", reg_addr); end
        n_tests++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL rd3_no_write: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) begin
            w0 = wr_cnt; r0 = rd_cnt;
            spi_xfer(1'(m >> 1), 1'(m & 1), 16, {SPI_RW_WRITE, 7'h01, 8'h5A}, 1'b0, 1'b0, rx_val);
            spi_xfer(1'(m >> 1), 1'(m & 1), 16, {SPI_RW_READ, 7'h01, 8'h00}, 1'b1, 1'b0, rx_val);
            n_tests++; if (wr_cnt - w0 !== 1 || last_wr_data !== 8'h5A) begin
                n_fail++; $display("FAIL b2b_write mode%0d: got %0d/%h want 1/5a", m, wr_cnt - w0, last_wr_data); end
            n_tests++; if (rd_cnt - r0 !== 1 || rx_val !== 8'h5A) begin
                n_fail++; $display("FAIL b2b_read mode%0d: got %0d/%h want 1/5a", m, rd_cnt - r0, rx_val); end
        end
    endtask

    task automatic test_abort();
        w0 = wr_cnt; f0 = ferr_cnt;
        spi_xfer(1'b0, 1'b0, 11, {SPI_RW_WRITE, 7'h03, 8'hFF}, 1'b0, 1'b0, rx_val);
        n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL abort_ferr: got %0d want 1", ferr_cnt - f0); end
        n_tests++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL abort_no_write: got %0d want 0", wr_cnt - w0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        spi_xfer(1'b0, 1'b0, 16, {SPI_RW_WRITE, 7'h03, 8'hFF}, 1'b0, 1'b0, rx_val);
        n_tests++; if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h03 || last_wr_data !== 8'hFF) begin
            n_fail++; $display("FAIL abort_recover: got %0d %h/%h want 1 03/ff", wr_cnt - w0, last_wr_addr, last_wr_data); end
        n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL abort_ferr_total: got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_extra_clocks();
        w0 = wr_cnt; f0 = ferr_cnt;
        spi_xfer(1'b0, 1'b0, 20, {SPI_RW_WRITE, 7'h7F, 8'h00}, 1'b0, 1'b0, rx_val);
        n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL extra_wr_count: got %0d want 1", wr_cnt - w0); end
        n_tests++; if (last_wr_addr !== 7'h7F || last_wr_data !== 8'h00) begin
            n_fail++; $display("FAIL extra_wr_value: got %h/%h want 7f/00", last_wr_addr, last_wr_data); end
        n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL extra_no_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_read();
        rd_force = 1'b1; rd_force_val = 8'h96;
        spi_xfer(1'b0, 1'b0, 12, {SPI_RW_READ, 7'h2A, 8'h00}, 1'b1, 1'b1, rx_val);
        n_tests++; if (dut.r_sdio_oe !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got oe=%b busy=%b want 1/1", dut.r_sdio_oe, busy); end
        reset = 1'b1;
        #1;
        n_tests++; if (dut.r_sdio_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe: got %b want 0", dut.r_sdio_oe); end
        n_tests++; if (busy !== 1'b0 || reg_addr !== 7'h00 || reg_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got busy=%b addr=%h rd=%b want 0/00/0", busy, reg_addr, reg_rd_en); end
        spi_cs_n = 1'b1;
        rd_force = 1'b0;
        @(negedge fabric_clk);
        repeat (2) @(negedge fabric_clk);
        reset = 1'b0;
        #(2*HALF);
        w0 = wr_cnt; f0 = ferr_cnt;
        spi_xfer(1'b0, 1'b0, 16, {SPI_RW_WRITE, 7'h2A, 8'hC3}, 1'b0, 1'b0, rx_val);
        n_tests++; if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h2A || last_wr_data !== 8'hC3) begin
            n_fail++; $display("FAIL rst_mid_next: got %0d %h/%h want 1 2a/c3", wr_cnt - w0, last_wr_addr, last_wr_data); end
        n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_write_mode0();
        test_read_mode3();
        test_back_to_back();
        test_abort();
        test_extra_clocks();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
